// File: rtl/axi_lite_to_reg.sv
// axi_lite_to_reg: AXI4-Lite slave to 32-bit register interface bridge, one transaction in flight.
package reg_intf;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_intf_req_a32_d32;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_intf_resp_d32;
  typedef reg_intf_resp_d32 reg_intf_req_d32;
endpackage

module axi_lite_to_reg
  import reg_intf::*;
#(
  parameter bit         RR_ARB   = 1'b1,
  parameter logic [1:0] ERR_RESP = 2'b10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         aw_addr_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [31:0]         w_data_i,
  input  logic [3:0]          w_strb_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [1:0]          b_resp_o,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  input  logic [31:0]         ar_addr_i,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  output logic [31:0]         r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output reg_intf_req_a32_d32 reg_req_o,
  input  reg_intf_req_d32     reg_rsp_i
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WRESP, S_RRESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_strb;
  logic        r_err, r_last_rd;
  logic        w_idle, w_gnt_wr, w_gnt_rd, w_req_valid, w_reg_hs;
  assign w_idle   = r_state == S_IDLE;
  // A tie goes to write unless round-robin says the last grant was already a write
  assign w_gnt_wr = w_idle && aw_valid_i && w_valid_i && (!ar_valid_i || !RR_ARB || r_last_rd);
  assign w_gnt_rd = w_idle && ar_valid_i && !w_gnt_wr;
  assign aw_ready_o  = w_gnt_wr;
  assign w_ready_o   = w_gnt_wr;
  assign ar_ready_o  = w_gnt_rd;
  assign w_req_valid = r_state == S_WRITE || r_state == S_READ;
  assign w_reg_hs    = w_req_valid && reg_rsp_i.ready;
  assign b_valid_o   = r_state == S_WRESP;
  assign r_valid_o   = r_state == S_RRESP;
  assign b_resp_o    = b_valid_o && r_err ? ERR_RESP : 2'b00;
  assign r_resp_o    = r_valid_o && r_err ? ERR_RESP : 2'b00;
  assign r_data_o    = r_rdata;
  always_comb begin
    reg_req_o = '0;
    if (w_req_valid) reg_req_o = '{addr: r_addr, write: r_state == S_WRITE, wdata: r_wdata, wstrb: r_strb, valid: 1'b1};
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_gnt_wr ? S_WRITE : w_gnt_rd ? S_READ : S_IDLE;
      S_WRITE: w_next = reg_rsp_i.ready ? S_WRESP : S_WRITE;
      S_READ:  w_next = reg_rsp_i.ready ? S_RRESP : S_READ;
      S_WRESP: w_next = b_ready_i ? S_IDLE : S_WRESP;
      S_RRESP: w_next = r_ready_i ? S_IDLE : S_RRESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_last_rd <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_gnt_wr) begin
        r_addr    <= aw_addr_i;
        r_wdata   <= w_data_i;
        r_strb    <= w_strb_i;
        r_last_rd <= 1'b0;
      end else if (w_gnt_rd) begin
        r_addr    <= ar_addr_i;
        r_wdata   <= '0;
        r_strb    <= '0;
        r_last_rd <= 1'b1;
      end
      if (w_reg_hs) begin
        r_err <= reg_rsp_i.error;
        if (r_state == S_READ) r_rdata <= reg_rsp_i.rdata;
      end
    end
  end
endmodule
